// File: rtl/pico16a_vga_pkg.sv
// Shared constants and helpers for the PICO16a VGA colour-cell display.
// Timing values are the 640x480@60 defaults; the cell buffer is 40x30 words of 12-bit RGB.
package pico16a_vga_pkg;

  localparam int H_ACT        = 640;
  localparam int H_FP         = 16;
  localparam int H_SYN        = 96;
  localparam int H_BP         = 48;
  localparam int H_TOTAL      = H_ACT + H_FP + H_SYN + H_BP;
  localparam int H_SYNC_START = H_ACT + H_FP;
  localparam int H_SYNC_END   = H_ACT + H_FP + H_SYN;

  localparam int V_ACT        = 480;
  localparam int V_FP         = 10;
  localparam int V_SYN        = 2;
  localparam int V_BP         = 33;
  localparam int V_TOTAL      = V_ACT + V_FP + V_SYN + V_BP;
  localparam int V_SYNC_START = V_ACT + V_FP;
  localparam int V_SYNC_END   = V_ACT + V_FP + V_SYN;

  localparam logic [15:0] BASE_ADRS = 16'hE000;
  localparam int          CELLS     = 1200;
  localparam int          COLS      = 40;
  localparam int          ROWS      = CELLS / COLS;

  // Replicate the nibble so full scale maps to full scale and zero stays zero.
  function automatic logic [9:0] expand4to10(input logic [3:0] c);
    return {c, c, c[3:2]};
  endfunction

endpackage

// File: rtl/pico16a_vga_timing.sv
// Free-running horizontal/vertical counters with raw (undelayed) sync and active flags.
module vga_timing
  import pico16a_vga_pkg::*;
#(
  parameter int HTOTAL      = H_TOTAL,
  parameter int HACTIVE     = H_ACT,
  parameter int HSYNC_START = H_SYNC_START,
  parameter int HSYNC_END   = H_SYNC_END,
  parameter int VTOTAL      = V_TOTAL,
  parameter int VACTIVE     = V_ACT,
  parameter int VSYNC_START = V_SYNC_START,
  parameter int VSYNC_END   = V_SYNC_END
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic [9:0] hcnt_o,
  output logic [9:0] vcnt_o,
  output logic       hs_o,
  output logic       vs_o,
  output logic       active_o
);

  localparam logic [9:0] H_LAST = 10'(HTOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(VTOTAL - 1);

  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;

  always_comb begin
    hcnt_d = hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign hcnt_o   = hcnt_q;
  assign vcnt_o   = vcnt_q;
  assign hs_o     = !((hcnt_q >= 10'(HSYNC_START)) && (hcnt_q < 10'(HSYNC_END)));
  assign vs_o     = !((vcnt_q >= 10'(VSYNC_START)) && (vcnt_q < 10'(VSYNC_END)));
  assign active_o = (hcnt_q < 10'(HACTIVE)) && (vcnt_q < 10'(VACTIVE));

endmodule

// File: rtl/pico16a_vga_ctrl.sv
// Memory-mapped 40x30 colour-cell VGA display: CPU-side read/write port into a dual-port
// cell RAM, display-side 2-clock pixel pipeline driving the VGA DAC pins.
module pico16a_vga_ctrl
  import pico16a_vga_pkg::*;
#(
  parameter int HACT = H_ACT,
  parameter int HFP  = H_FP,
  parameter int HSYN = H_SYN,
  parameter int HBP  = H_BP,
  parameter int VACT = V_ACT,
  parameter int VFP  = V_FP,
  parameter int VSYN = V_SYN,
  parameter int VBP  = V_BP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] adrs,
  input  logic [15:0] from_cpu,
  input  logic        we,
  output logic [15:0] rdata,
  output logic        rsel,
  output logic [9:0]  VGA_R,
  output logic [9:0]  VGA_G,
  output logic [9:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK,
  output logic        VGA_SYNC,
  output logic        VGA_CLK
);

  localparam logic [15:0] LAST_ADRS = BASE_ADRS + 16'(CELLS - 1);

  logic [9:0]  hcnt, vcnt;
  logic        hs_raw, vs_raw, act_raw;
  logic [4:0]  row;
  logic [5:0]  col;
  logic [10:0] disp_idx;
  logic [15:0] cpu_off;
  logic [10:0] cpu_idx;

  logic [11:0] cell_ram [CELLS];

  logic [11:0] pix_p1;
  logic        hs_p1, vs_p1, act_p1;
  logic        hs_p2, vs_p2, act_p2;
  logic [9:0]  r_p2, g_p2, b_p2;
  logic [15:0] rdata_q;

  vga_timing #(
    .HTOTAL      (HACT + HFP + HSYN + HBP),
    .HACTIVE     (HACT),
    .HSYNC_START (HACT + HFP),
    .HSYNC_END   (HACT + HFP + HSYN),
    .VTOTAL      (VACT + VFP + VSYN + VBP),
    .VACTIVE     (VACT),
    .VSYNC_START (VACT + VFP),
    .VSYNC_END   (VACT + VFP + VSYN)
  ) u_timing (
    .clk_i    (clk),
    .rst_ni   (rst),
    .hcnt_o   (hcnt),
    .vcnt_o   (vcnt),
    .hs_o     (hs_raw),
    .vs_o     (vs_raw),
    .active_o (act_raw)
  );

  // row*40 + col as shifts; outside the visible cell grid the index parks on cell 0.
  assign row = vcnt[8:4];
  assign col = hcnt[9:4];
  always_comb begin
    disp_idx = '0;
    if (act_raw && (row < 5'(ROWS)) && (col < 6'(COLS)))
      disp_idx = (11'(row) << 5) + (11'(row) << 3) + 11'(col);
  end

  assign cpu_off = adrs - BASE_ADRS;
  assign cpu_idx = cpu_off[10:0];
  assign rsel    = (adrs >= BASE_ADRS) && (adrs <= LAST_ADRS);

  // Both ports sample the old word when they collide with a CPU write (read-before-write).
  always_ff @(posedge clk) begin
    if (we && rsel)
      cell_ram[cpu_idx] <= from_cpu[11:0];
    pix_p1 <= cell_ram[disp_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rdata_q <= '0;
    else
      rdata_q <= rsel ? {4'h0, cell_ram[cpu_idx]} : 16'h0000;
  end

  // Stage 1: RAM word registered; syncs and active follow one clock behind the counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_p1  <= 1'b1;
      vs_p1  <= 1'b1;
      act_p1 <= 1'b0;
    end else begin
      hs_p1  <= hs_raw;
      vs_p1  <= vs_raw;
      act_p1 <= act_raw;
    end
  end

  // Stage 2: expanded colour, blanked outside the active area, aligned with delayed syncs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_p2  <= 1'b1;
      vs_p2  <= 1'b1;
      act_p2 <= 1'b0;
      r_p2   <= '0;
      g_p2   <= '0;
      b_p2   <= '0;
    end else begin
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
      act_p2 <= act_p1;
      r_p2   <= act_p1 ? expand4to10(pix_p1[11:8]) : 10'h000;
      g_p2   <= act_p1 ? expand4to10(pix_p1[7:4])  : 10'h000;
      b_p2   <= act_p1 ? expand4to10(pix_p1[3:0])  : 10'h000;
    end
  end

  assign rdata     = rdata_q;
  assign VGA_R     = r_p2;
  assign VGA_G     = g_p2;
  assign VGA_B     = b_p2;
  assign VGA_HS    = hs_p2;
  assign VGA_VS    = vs_p2;
  assign VGA_BLANK = act_p2;
  assign VGA_SYNC  = 1'b0;
  assign VGA_CLK   = clk;

  logic unused_bits;
  assign unused_bits = ^{hcnt[3:0], vcnt[9], vcnt[3:0], cpu_off[15:11], from_cpu[15:12]};

endmodule

// File: tb/tb_pico16a_vga_ctrl.sv
// Directed bench for pico16a_vga_ctrl with a shortened vertical frame (32 active lines,
// 39 total) so whole frames fit in a short run; horizontal timing is the full 800 clocks.
module tb_pico16a_vga_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] adrs = 16'h0000;
  logic [15:0] from_cpu = 16'h0000;
  logic        we = 1'b0;
  logic [15:0] rdata;
  logic        rsel;
  logic [9:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_CLK;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc;

  pico16a_vga_ctrl #(
    .VACT(32), .VFP(2), .VSYN(2), .VBP(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .adrs      (adrs),
    .from_cpu  (from_cpu),
    .we        (we),
    .rdata     (rdata),
    .rsel      (rsel),
    .VGA_R     (VGA_R),
    .VGA_G     (VGA_G),
    .VGA_B     (VGA_B),
    .VGA_HS    (VGA_HS),
    .VGA_VS    (VGA_VS),
    .VGA_BLANK (VGA_BLANK),
    .VGA_SYNC  (VGA_SYNC),
    .VGA_CLK   (VGA_CLK)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; output for pixel (h,v) appears at cyc = v*800 + h + 2.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_pix(input string tag, input logic [9:0] r, input logic [9:0] g,
                         input logic [9:0] b, input logic blank);
    chk({tag, "_r"}, 32'(VGA_R), 32'(r));
    chk({tag, "_g"}, 32'(VGA_G), 32'(g));
    chk({tag, "_b"}, 32'(VGA_B), 32'(b));
    chk({tag, "_blank"}, 32'(VGA_BLANK), 32'(blank));
  endtask

  task automatic wait_to(input int target);
    if (cyc > target) begin
      n_chk++;
      $display("FAIL wait_%0d: cycle %0d already past", target, cyc);
    end
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    adrs = a; from_cpu = d; we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic check_release_timing(input string tag, input logic [9:0] r, input logic [9:0] b);
    wait_to(2);   chk_pix({tag, "_pix00"}, r, 10'h000, b, 1'b1);
    wait_to(657); chk({tag, "_hs_before"}, 32'(VGA_HS), 32'd1);
    wait_to(658); chk({tag, "_hs_fall"},   32'(VGA_HS), 32'd0);
    wait_to(753); chk({tag, "_hs_last"},   32'(VGA_HS), 32'd0);
    wait_to(754); chk({tag, "_hs_rise"},   32'(VGA_HS), 32'd1);
  endtask

  initial begin
    // Reset state with clock running.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hs", 32'(VGA_HS), 32'd1);
    chk("rst_vs", 32'(VGA_VS), 32'd1);
    chk_pix("rst", 10'h000, 10'h000, 10'h000, 1'b0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_sync", 32'(VGA_SYNC), 32'd0);

    // Load the cell buffer while held in reset (RAM is not reset).
    for (int i = 0; i < 1200; i++) wr(16'hE000 + 16'(i), 16'h0000);
    wr(16'hE000, 16'h0F00);   // cell 0: red
    wr(16'hE028, 16'h0FFF);   // cell 40 (row 1, col 0): white
    wr(16'hE04F, 16'h00F0);   // cell 79 (row 1, col 39): green
    wr(16'hE050, 16'h0FFF);   // cell 80: white, lies under vertical blanking
    wr(16'hE4AF, 16'h00F0);   // last cell
    rst = 1'b1;

    wait_to(2);  chk_pix("pix_0_0", 10'h3FF, 10'h000, 10'h000, 1'b1);
    wait_to(17); chk_pix("pix_15_0", 10'h3FF, 10'h000, 10'h000, 1'b1);
    wait_to(18); chk_pix("pix_16_0", 10'h000, 10'h000, 10'h000, 1'b1);

    wait_to(20);
    adrs = 16'hE123; from_cpu = 16'hF5A3; we = 1'b1;
    wait_to(21); we = 1'b0;
    wait_to(22);
    chk("rb_e123", 32'(rdata), 32'h05A3);
    chk("rsel_e123", 32'(rsel), 32'd1);
    adrs = 16'hE4B0; from_cpu = 16'h0FFF; we = 1'b1;
    #1 chk("rsel_e4b0", 32'(rsel), 32'd0);
    wait_to(23);
    we = 1'b0;
    chk("rb_e4b0", 32'(rdata), 32'h0000);
    adrs = 16'hE4AF;
    wait_to(24); chk("rb_e4af", 32'(rdata), 32'h00F0);
    adrs = 16'hE000;
    wait_to(25); chk("rb_e000", 32'(rdata), 32'h0F00);
    adrs = 16'hDFFF;
    wait_to(26);
    chk("rb_dfff", 32'(rdata), 32'h0000);
    chk("rsel_dfff", 32'(rsel), 32'd0);

    wait_to(641); chk_pix("pix_639_0", 10'h000, 10'h000, 10'h000, 1'b1);
    wait_to(642); chk_pix("hblank_640_0", 10'h000, 10'h000, 10'h000, 1'b0);
    wait_to(657); chk("hs_before", 32'(VGA_HS), 32'd1);
    wait_to(658); chk("hs_fall", 32'(VGA_HS), 32'd0);
    wait_to(753); chk("hs_last_low", 32'(VGA_HS), 32'd0);
    wait_to(754); chk("hs_rise", 32'(VGA_HS), 32'd1);
    wait_to(1457); chk("hs_l1_before", 32'(VGA_HS), 32'd1);
    wait_to(1458); chk("hs_l1_fall", 32'(VGA_HS), 32'd0);

    wait_to(12002); chk_pix("pix_0_15", 10'h3FF, 10'h000, 10'h000, 1'b1);
    wait_to(12802); chk_pix("pix_0_16", 10'h3FF, 10'h3FF, 10'h3FF, 1'b1);
    wait_to(25425); chk_pix("pix_623_31", 10'h000, 10'h000, 10'h000, 1'b1);
    wait_to(25441); chk_pix("pix_639_31", 10'h000, 10'h3FF, 10'h000, 1'b1);
    wait_to(25602); chk_pix("vblank_0_32", 10'h000, 10'h000, 10'h000, 1'b0);
    wait_to(27201); chk("vs_before", 32'(VGA_VS), 32'd1);
    wait_to(27202); chk("vs_fall", 32'(VGA_VS), 32'd0);
    wait_to(28801); chk("vs_last_low", 32'(VGA_VS), 32'd0);
    wait_to(28802); chk("vs_rise", 32'(VGA_VS), 32'd1);

    // Write cell 0 on the very edge the display reads it: pixel (0,0) keeps the old colour.
    wait_to(31200);
    adrs = 16'hE000; from_cpu = 16'h000F; we = 1'b1;
    wait_to(31201); we = 1'b0;
    wait_to(31202); chk_pix("f1_pix_0_0_old", 10'h3FF, 10'h000, 10'h000, 1'b1);
    chk("f1_vs", 32'(VGA_VS), 32'd1);
    wait_to(31203); chk_pix("f1_pix_1_0_new", 10'h000, 10'h000, 10'h3FF, 1'b1);

    // Mid-frame reset at line 5 of the second frame.
    wait_to(35202);
    rst = 1'b0;
    #1;
    chk("mid_rst_hs", 32'(VGA_HS), 32'd1);
    chk("mid_rst_vs", 32'(VGA_VS), 32'd1);
    chk_pix("mid_rst", 10'h000, 10'h000, 10'h000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    check_release_timing("mid", 10'h000, 10'h3FF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
